gpio_input_conditioner: RTL and testbench
=========================================

Name: gpio_input_conditioner

Overview:
Per-pin input conditioning stage that sits directly upstream of the GPIO lite block.
- Synchronises asynchronous pad inputs into the pclk domain.
- Optionally debounces each pin with a programmable stability count.
- Drives the conditioned vector into the GPIO block's gpio_pin_in port.
- Also produces per-pin rise/fall event pulses and a summary change flag for the subsystem interrupt logic.

Parameters:
NUM_PINS, 16, number of GPIO pins conditioned
CNT_W, 8, width of per-pin debounce counter and of db_limit
SYNC_STAGES, 2, flops in synchroniser chain (legal 2..4)

Ports:
pclk  input  1  peripheral clock; all state updates on rising edge
p_reset  input  1  synchronous active-high reset
pin_raw  input  NUM_PINS  asynchronous pad inputs
db_enable  input  NUM_PINS  per-pin debounce enable (1 = debounce, 0 = bypass); quasi-static
db_limit  input  CNT_W  debounce stability threshold, shared by all pins
pin_clean  output  NUM_PINS  conditioned pin values; connect to GPIO gpio_pin_in
pin_rise  output  NUM_PINS  one-cycle pulse: pin_clean bit went 0->1
pin_fall  output  NUM_PINS  one-cycle pulse: pin_clean bit went 1->0
any_change  output  1  OR-reduction of pin_rise|pin_fall (combinational from registered pulses)

Behaviour:
Reset:
- p_reset high at a pclk edge clears sync chain, counters, pin_clean, pin_rise and pin_fall to 0.
- any_change is therefore 0.
- Reset takes priority over all other activity, including mid-count.

Synchroniser:
- Per bit: SYNC_STAGES-deep flop chain.
- sync_q is the last stage output; no logic between stages.

Per-pin datapath, evaluated each edge, reset inactive:
- Bypass (db_enable[i]=0):
  - cnt[i] <= 0.
  - pin_clean[i] <= sync_q[i].
- Debounce (db_enable[i]=1), sync_q[i] == pin_clean[i]:
  - cnt[i] <= 0; pin_clean holds.
- Debounce, sync_q[i] != pin_clean[i], cnt[i] >= db_limit:
  - pin_clean[i] <= sync_q[i].
  - cnt[i] <= 0.
- Debounce, sync_q[i] != pin_clean[i], cnt[i] < db_limit:
  - cnt[i] <= cnt[i]+1; pin_clean holds.
- Stability requirement: a new level must be seen on sync_q for db_limit+1 consecutive cycles before pin_clean changes.
- Any glitch back to the old level restarts the count from 0.
- db_limit=0 behaves identically to bypass.

Latency:
- Raw step to pin_clean change is SYNC_STAGES + db_limit + 1 pclk edges in debounce mode.
- It is SYNC_STAGES + 1 edges in bypass.
- Maximum db_limit (2^CNT_W - 1) is legal; the counter never wraps because it clears at the limit.

Edge pulses:
- pin_rise[i] and pin_fall[i] are registered at the same edge that updates pin_clean[i].
- They are high exactly in the first cycle pin_clean shows the new value, then return to 0 the next cycle unless another change occurs.
- pin_rise and pin_fall for the same bit are never both high.

Changes to db_limit mid-count:
- The >= comparison applies immediately.
- Lowering db_limit below the current cnt causes the update on the next mismatching edge.

Changes to db_enable mid-count:
- Deasserting switches the pin to bypass next edge and clears the count.
- Asserting starts debounce with cnt = 0.

Post-reset behaviour:
- Pins held high through reset produce pin_clean=1 plus a pin_rise pulse after the normal latency.
- This is intentional; downstream masks events until configured.

Pins are fully independent. Simultaneous events on multiple pins are all reported in the same cycle.

Test Plan:
1. Reset: drive pin_raw=16'hFFFF with p_reset high for 4 cycles. Required: pin_clean=0, pin_rise=0, any_change=0 throughout.
2. Reset release: release p_reset with pin_raw held at 16'hFFFF. Required: pin_clean=16'hFFFF and pin_rise=16'hFFFF for exactly one cycle, 3 edges after release (bypass, SYNC_STAGES=2).
3. Debounce rise: db_enable=16'h0001, db_limit=5, pin_raw[0] steps 0->1. Required: pin_clean[0] rises 2+5+1=8 edges after the step, with a single pin_rise[0] pulse and any_change=1 for that cycle.
4. Glitch rejection: db_limit=5, pin_raw[0] held high 3 cycles, low 1 cycle, then high. Required: cnt restarts; pin_clean[0] rises 8 edges after the final high step; no pulse from the glitch.
5. Limit lowered mid-count: db_limit=200 with pin_raw[3] mismatching for 50 cycles, then db_limit set to 10. Required: pin_clean[3] updates on the next edge; cnt returns to 0.
6. Simultaneous and mid-operation reset:
   - Pins 4 (0->1) and 9 (1->0) in bypass at the same edge. Required: pin_rise=16'h0010 and pin_fall=16'h0200 in the same cycle.
   - Then p_reset asserted mid-count on a debounced pin. Required: all outputs 0 at the next edge.

Source files
------------

// File: rtl/gpio_input_conditioner.sv
// Per-pin GPIO input conditioning: pad synchroniser, optional debounce filter,
// and registered rise/fall event pulses for the interrupt logic.
module gpio_input_conditioner #(
  parameter int NUM_PINS    = 16,
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                pclk,
  input  logic                p_reset,
  input  logic [NUM_PINS-1:0] pin_raw,
  input  logic [NUM_PINS-1:0] db_enable,
  input  logic [CNT_W-1:0]    db_limit,
  output logic [NUM_PINS-1:0] pin_clean,
  output logic [NUM_PINS-1:0] pin_rise,
  output logic [NUM_PINS-1:0] pin_fall,
  output logic                any_change
);

  logic [SYNC_STAGES-1:0][NUM_PINS-1:0] sync_chain_q, sync_chain_d;
  logic [NUM_PINS-1:0]                  sync_q;
  logic [NUM_PINS-1:0][CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_PINS-1:0]                  pin_clean_q, pin_clean_d;
  logic [NUM_PINS-1:0]                  pin_rise_q, pin_rise_d;
  logic [NUM_PINS-1:0]                  pin_fall_q, pin_fall_d;

  always_comb begin
    sync_chain_d[0] = pin_raw;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_chain_d[k] = sync_chain_q[k-1];
    end
  end

  assign sync_q = sync_chain_q[SYNC_STAGES-1];

  // The counter clears as soon as it reaches the limit, so it can never wrap
  // even with the maximum db_limit.
  always_comb begin
    cnt_d       = cnt_q;
    pin_clean_d = pin_clean_q;
    for (int i = 0; i < NUM_PINS; i++) begin
      if (!db_enable[i]) begin
        cnt_d[i]       = '0;
        pin_clean_d[i] = sync_q[i];
      end else if (sync_q[i] == pin_clean_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] >= db_limit) begin
        cnt_d[i]       = '0;
        pin_clean_d[i] = sync_q[i];
      end else begin
        cnt_d[i] = CNT_W'(cnt_q[i] + 1'b1);
      end
    end
    pin_rise_d = pin_clean_d & ~pin_clean_q;
    pin_fall_d = ~pin_clean_d & pin_clean_q;
  end

  always_ff @(posedge pclk) begin
    if (p_reset) begin
      sync_chain_q <= '0;
      cnt_q        <= '0;
      pin_clean_q  <= '0;
      pin_rise_q   <= '0;
      pin_fall_q   <= '0;
    end else begin
      sync_chain_q <= sync_chain_d;
      cnt_q        <= cnt_d;
      pin_clean_q  <= pin_clean_d;
      pin_rise_q   <= pin_rise_d;
      pin_fall_q   <= pin_fall_d;
    end
  end

  assign pin_clean  = pin_clean_q;
  assign pin_rise   = pin_rise_q;
  assign pin_fall   = pin_fall_q;
  assign any_change = |(pin_rise_q | pin_fall_q);

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Directed self-checking bench for gpio_input_conditioner (default parameters).
module tb_gpio_input_conditioner;

  logic        pclk;
  logic        p_reset;
  logic [15:0] pin_raw;
  logic [15:0] db_enable;
  logic [7:0]  db_limit;
  logic [15:0] pin_clean;
  logic [15:0] pin_rise;
  logic [15:0] pin_fall;
  logic        any_change;

  int checks;
  int errors;

  gpio_input_conditioner #(.NUM_PINS(16), .CNT_W(8), .SYNC_STAGES(2)) dut (
    .pclk       (pclk),
    .p_reset    (p_reset),
    .pin_raw    (pin_raw),
    .db_enable  (db_enable),
    .db_limit   (db_limit),
    .pin_clean  (pin_clean),
    .pin_rise   (pin_rise),
    .pin_fall   (pin_fall),
    .any_change (any_change)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Advance one rising edge and settle; inputs are changed and outputs sampled here.
  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic test_reset();
    p_reset   = 1'b1;
    pin_raw   = 16'hFFFF;
    db_enable = 16'h0000;
    db_limit  = 8'd0;
    for (int t = 0; t < 4; t++) begin
      tick();
      checks++;
      if (pin_clean !== 16'h0000 || pin_rise !== 16'h0000 || pin_fall !== 16'h0000 || any_change !== 1'b0) begin
        errors++;
        $display("FAIL reset cycle %0d: clean=%h rise=%h fall=%h any=%b, expected all 0", t, pin_clean, pin_rise, pin_fall, any_change);
      end
    end
  endtask

  task automatic test_reset_release();
    p_reset = 1'b0;
    for (int t = 1; t <= 4; t++) begin
      logic [15:0] exp_clean, exp_rise;
      tick();
      exp_clean = (t >= 3) ? 16'hFFFF : 16'h0000;
      exp_rise  = (t == 3) ? 16'hFFFF : 16'h0000;
      checks++;
      if (pin_clean !== exp_clean || pin_rise !== exp_rise || any_change !== (t == 3)) begin
        errors++;
        $display("FAIL release edge %0d: clean=%h rise=%h any=%b, expected clean=%h rise=%h any=%b", t, pin_clean, pin_rise, any_change, exp_clean, exp_rise, t == 3);
      end
    end
    pin_raw = 16'h0000;
    for (int t = 0; t < 4; t++) tick();
    checks++;
    if (pin_clean !== 16'h0000) begin
      errors++;
      $display("FAIL release_clear: clean=%h expected 0000", pin_clean);
    end
  endtask

  task automatic test_debounce_rise();
    db_enable = 16'h0001;
    db_limit  = 8'd5;
    pin_raw   = 16'h0001;
    for (int t = 1; t <= 9; t++) begin
      logic [15:0] exp_clean, exp_rise;
      tick();
      exp_clean = (t >= 8) ? 16'h0001 : 16'h0000;
      exp_rise  = (t == 8) ? 16'h0001 : 16'h0000;
      checks++;
      if (pin_clean !== exp_clean || pin_rise !== exp_rise || any_change !== (t == 8)) begin
        errors++;
        $display("FAIL debounce_rise edge %0d: clean=%h rise=%h any=%b, expected clean=%h rise=%h any=%b", t, pin_clean, pin_rise, any_change, exp_clean, exp_rise, t == 8);
      end
    end
  endtask

  task automatic test_glitch();
    // db_limit=0 on a debounced pin must act exactly like bypass.
    db_limit = 8'd0;
    pin_raw  = 16'h0000;
    for (int t = 1; t <= 3; t++) tick();
    checks++;
    if (pin_clean !== 16'h0000 || pin_fall !== 16'h0001) begin
      errors++;
      $display("FAIL limit0_fall: clean=%h fall=%h, expected clean=0000 fall=0001", pin_clean, pin_fall);
    end
    tick();
    db_limit = 8'd5;
    pin_raw  = 16'h0001;
    for (int t = 0; t < 3; t++) tick();
    pin_raw = 16'h0000;
    tick();
    pin_raw = 16'h0001;
    for (int t = 1; t <= 8; t++) begin
      logic [15:0] exp_clean, exp_rise;
      tick();
      exp_clean = (t == 8) ? 16'h0001 : 16'h0000;
      exp_rise  = (t == 8) ? 16'h0001 : 16'h0000;
      checks++;
      if (pin_clean !== exp_clean || pin_rise !== exp_rise) begin
        errors++;
        $display("FAIL glitch edge %0d: clean=%h rise=%h, expected clean=%h rise=%h", t, pin_clean, pin_rise, exp_clean, exp_rise);
      end
    end
  endtask

  task automatic test_limit_lowered();
    db_enable = 16'h0009;
    db_limit  = 8'd200;
    pin_raw   = 16'h0009;
    for (int t = 0; t < 52; t++) tick();
    checks++;
    if (pin_clean !== 16'h0001 || any_change !== 1'b0) begin
      errors++;
      $display("FAIL limit_hold: clean=%h any=%b, expected clean=0001 any=0", pin_clean, any_change);
    end
    db_limit = 8'd10;
    tick();
    checks++;
    if (pin_clean !== 16'h0009 || pin_rise !== 16'h0008) begin
      errors++;
      $display("FAIL limit_lowered: clean=%h rise=%h, expected clean=0009 rise=0008", pin_clean, pin_rise);
    end
    // A cleared count means the return to low takes the full 2+10+1 edges.
    pin_raw = 16'h0001;
    for (int t = 1; t <= 13; t++) begin
      logic [15:0] exp_clean, exp_fall;
      tick();
      exp_clean = (t == 13) ? 16'h0001 : 16'h0009;
      exp_fall  = (t == 13) ? 16'h0008 : 16'h0000;
      checks++;
      if (pin_clean !== exp_clean || pin_fall !== exp_fall) begin
        errors++;
        $display("FAIL cnt_cleared edge %0d: clean=%h fall=%h, expected clean=%h fall=%h", t, pin_clean, pin_fall, exp_clean, exp_fall);
      end
    end
  endtask

  task automatic test_back_to_back();
    pin_raw = 16'h0201;
    for (int t = 0; t < 4; t++) tick();
    checks++;
    if (pin_clean !== 16'h0201) begin
      errors++;
      $display("FAIL simul_setup: clean=%h expected 0201", pin_clean);
    end
    pin_raw = 16'h0011;
    for (int t = 1; t <= 4; t++) begin
      logic [15:0] exp_rise, exp_fall, exp_clean;
      tick();
      exp_clean = (t >= 3) ? 16'h0011 : 16'h0201;
      exp_rise  = (t == 3) ? 16'h0010 : 16'h0000;
      exp_fall  = (t == 3) ? 16'h0200 : 16'h0000;
      checks++;
      if (pin_clean !== exp_clean || pin_rise !== exp_rise || pin_fall !== exp_fall || any_change !== (t == 3)) begin
        errors++;
        $display("FAIL simul edge %0d: clean=%h rise=%h fall=%h any=%b, expected clean=%h rise=%h fall=%h any=%b", t, pin_clean, pin_rise, pin_fall, any_change, exp_clean, exp_rise, exp_fall, t == 3);
      end
    end
  endtask

  task automatic test_mid_reset();
    db_limit = 8'd5;
    pin_raw  = 16'h0010;
    for (int t = 0; t < 4; t++) tick();
    checks++;
    if (pin_clean !== 16'h0011) begin
      errors++;
      $display("FAIL midcount_hold: clean=%h expected 0011", pin_clean);
    end
    p_reset = 1'b1;
    for (int t = 0; t < 2; t++) begin
      tick();
      checks++;
      if (pin_clean !== 16'h0000 || pin_rise !== 16'h0000 || pin_fall !== 16'h0000 || any_change !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset cycle %0d: clean=%h rise=%h fall=%h any=%b, expected all 0", t, pin_clean, pin_rise, pin_fall, any_change);
      end
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    p_reset   = 1'b1;
    pin_raw   = 16'h0000;
    db_enable = 16'h0000;
    db_limit  = 8'd0;
    test_reset();
    test_reset_release();
    test_debounce_rise();
    test_glitch();
    test_limit_lowered();
    test_back_to_back();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
